// File: rtl/four_bit_adder.sv
// four_bit_adder: 4-bit ripple-carry adder, a + b + cin, with registered,
// valid-qualified outputs and one cycle of latency.
// Ports:
//   clk, rst (async, active-high)
//   in_valid, a[3:0], b[3:0], cin  -- operands, sampled on rising clk
//   s0..s3, co                     -- registered sum bits and carry-out
//   out_valid                      -- high for one cycle per loaded result
//   ovf                            -- signed overflow, only with
//                                     FOUR_BIT_ADDER_OVF_EN defined
module four_bit_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic       co,
`ifdef FOUR_BIT_ADDER_OVF_EN
    output logic       ovf,
`endif
    output logic       out_valid
);

    // c[i] is the carry into stage i; c[4] is the carry-out.
    logic [4:0] c;
    logic [3:0] sum_c;

    always_comb begin
        c     = '0;
        sum_c = '0;
        c[0]  = cin;
        for (int i = 0; i < 4; i++) begin
            sum_c[i] = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    logic [3:0] sum_q, sum_d;
    logic       co_q, co_d;
    logic       out_valid_q, out_valid_d;

    // Result registers hold on idle cycles; only the valid flag drops.
    always_comb begin
        sum_d       = sum_q;
        co_d        = co_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = sum_c;
            co_d        = c[4];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            co_q        <= co_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef FOUR_BIT_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = c[3] ^ c[4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign s0        = sum_q[0];
    assign s1        = sum_q[1];
    assign s2        = sum_q[2];
    assign s3        = sum_q[3];
    assign co        = co_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_four_bit_adder.sv
// tb_four_bit_adder: directed-vector bench for four_bit_adder.
// Inputs change on the falling edge; outputs are checked on the next one.
module tb_four_bit_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       cin;
    logic       s0, s1, s2, s3, co, out_valid;
`ifdef FOUR_BIT_ADDER_OVF_EN
    logic       ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    four_bit_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (in_a),
        .b         (in_b),
        .cin       (cin),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .s3        (s3),
        .co        (co),
`ifdef FOUR_BIT_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] res();
        return {co, s3, s2, s1, s0};
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive operands at a falling edge, then wait one full cycle.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb,
                        input logic tc, input logic tv);
        in_a     = ta;
        in_b     = tb;
        cin      = tc;
        in_valid = tv;
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        cin      = 1'b0;

        #2;
        check("rst_res", 32'(res()), 32'h0);
        check("rst_vld", 32'(out_valid), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        step(4'd0, 4'd0, 1'b0, 1'b0);
        check("idle_res", 32'(res()), 32'h0);
        check("idle_vld", 32'(out_valid), 32'h0);

        step(4'd15, 4'd15, 1'b1, 1'b1);
        check("max_res", 32'(res()), 32'h1f);
        check("max_vld", 32'(out_valid), 32'h1);

        step(4'd0, 4'd0, 1'b0, 1'b1);
        check("zero_res", 32'(res()), 32'h00);

        step(4'd15, 4'd0, 1'b1, 1'b1);
        check("cin_wrap", 32'(res()), 32'h10);

        step(4'd7, 4'd7, 1'b1, 1'b1);
        check("cin_7_7", 32'(res()), 32'h0f);

        step(4'd3, 4'd4, 1'b0, 1'b1);
        check("hold_load", 32'(res()), 32'h07);
        check("hold_lvld", 32'(out_valid), 32'h1);
        step(4'd12, 4'd12, 1'b0, 1'b0);
        check("hold_res", 32'(res()), 32'h07);
        check("hold_vld", 32'(out_valid), 32'h0);

        step(4'd1, 4'd1, 1'b0, 1'b1);
        check("b2b_0", 32'(res()), 32'h02);
        check("b2b_0v", 32'(out_valid), 32'h1);
        step(4'd15, 4'd1, 1'b0, 1'b1);
        check("b2b_1", 32'(res()), 32'h10);
        check("b2b_1v", 32'(out_valid), 32'h1);
        step(4'd8, 4'd8, 1'b0, 1'b1);
        check("b2b_2", 32'(res()), 32'h10);
        check("b2b_2v", 32'(out_valid), 32'h1);

        step(4'd9, 4'd8, 1'b0, 1'b1);
        check("ex_9_8", 32'(res()), 32'h11);

        // Asynchronous reset between clock edges, with a load pending.
        in_a     = 4'd5;
        in_b     = 4'd5;
        cin      = 1'b0;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_res", 32'(res()), 32'h0);
        check("arst_vld", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("arst_hold", 32'(res()), 32'h0);
        rst = 1'b0;
        step(4'd6, 4'd6, 1'b0, 1'b0);
        check("post_rst", 32'(res()), 32'h0);
        check("post_vld", 32'(out_valid), 32'h0);
        step(4'd2, 4'd3, 1'b0, 1'b1);
        check("first_ld", 32'(res()), 32'h05);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                step(4'(i), 4'(j), 1'b0, 1'b1);
                check($sformatf("exh_%0d_%0d", i, j),
                      32'(res()), 32'(i + j));
            end
        end
        check("exh_vld", 32'(out_valid), 32'h1);

`ifdef FOUR_BIT_ADDER_OVF_EN
        step(4'd7, 4'd1, 1'b0, 1'b1);
        check("ovf_7_1", 32'(ovf), 32'h1);
        step(4'd8, 4'd8, 1'b0, 1'b1);
        check("ovf_8_8", 32'(ovf), 32'h1);
        step(4'd3, 4'd2, 1'b0, 1'b1);
        check("ovf_3_2", 32'(ovf), 32'h0);
        step(4'd7, 4'd1, 1'b0, 1'b0);
        check("ovf_hold", 32'(ovf), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/four_bit_adder.md
Name: four_bit_adder

Overview:
- 4-bit parallel (ripple-carry) adder built from four full-adder stages, with registered outputs.
- Adds two 4-bit unsigned operands plus carry-in, giving a 4-bit sum (individual bit outputs s0..s3) and carry-out.
- Arithmetic leaf block used by datapath logic; one-cycle latency, valid-qualified.

Parameters:
- None. Operand width is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid this cycle
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- cin  input  1  carry-in
- s0  output  1  sum bit 0 (LSB), registered
- s1  output  1  sum bit 1, registered
- s2  output  1  sum bit 2, registered
- s3  output  1  sum bit 3 (MSB), registered
- co  output  1  carry-out, registered
- out_valid  output  1  outputs hold a fresh result

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- Combinational core: four chained full-adder stages.
  - Stage i: sum_i = a[i] ^ b[i] ^ c_i.
  - Stage i: c_(i+1) = (a[i]&b[i]) | (c_i&(a[i]^b[i])).
  - c_0 = cin; co = c_4.
- Result equals {co,s3,s2,s1,s0} = a + b + cin, range 0..31. No truncation; carry-out is bit 4 of the sum.
- Reset: while rst is high, s0..s3, co and out_valid are 0 immediately, with no clock needed. The first capture happens on the first rising clk edge after rst deasserts.
- Latency: result appears 1 cycle after the rising edge at which in_valid=1 is sampled.
  - When in_valid=1: s0..s3 and co load the sum; out_valid <= 1.
  - When in_valid=0: s0..s3 and co hold their previous values; out_valid <= 0.
- Back-to-back: in_valid may be high every cycle; each cycle's result appears on the next edge. No stalls and no backpressure.
- Reset mid-operation: any in-flight result is discarded; outputs go to 0 asynchronously.
- Boundaries:
  - a=15, b=15, cin=1 -> sum 1111, co=1.
  - a=0, b=0, cin=0 -> all zero, co=0.
  - Wrap-around: a+b+cin >= 16 sets co=1 and the sum is the low 4 bits.
- No X propagation: with known inputs, outputs are always 0 or 1.

Optional Feature:
- Macro: FOUR_BIT_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, registered alongside the sum).
  - ovf = c_3 ^ c_4, the two's-complement signed-overflow indication for a 4-bit signed add.
  - Resets to 0 and follows the same in_valid load/hold rules as the sum.
- When undefined: port ovf does not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with outputs nonzero -> s0..s3, co and out_valid go to 0 without a clock edge; they stay 0 until the first in_valid after release.
- Exhaustive, cin=0: all 256 pairs a=0..15, b=0..15, one per cycle with in_valid=1.
  - Each cycle, {co,s3,s2,s1,s0} = a+b one cycle later.
  - Example: a=9, b=8 -> sum 0001, co=1.
- Carry-in: a=15, b=0, cin=1 -> sum 0000, co=1; a=7, b=7, cin=1 -> sum 1111, co=0.
- Hold: apply a=3, b=4 with in_valid=1, then in_valid=0 with a=12, b=12 -> outputs remain 0111, co=0; out_valid drops to 0.
- Back-to-back: a=1,b=1; a=15,b=1; a=8,b=8 on consecutive cycles -> outputs 0010/co0, 0000/co1, 0000/co1 on consecutive cycles with out_valid=1.
- FOUR_BIT_ADDER_OVF_EN defined: a=7, b=1, cin=0 -> ovf=1; a=8, b=8 -> ovf=1; a=3, b=2 -> ovf=0.
